// File: rtl/nonce_buffer_reader.sv
// Winning-nonce FIFO with a byte serializer toward the host link.
// Nonces are sent most significant byte first under valid/ready.
module nonce_buffer_reader #(
  parameter int DEPTH     = 8,
  parameter int NONCEBITS = 32,
  parameter int LOGDEPTH  = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 resultValid,
  input  logic                 success,
  input  logic [NONCEBITS-1:0] nonce,
  input  logic                 clear,
  output logic                 outValid,
  output logic [7:0]           outByte,
  input  logic                 outReady,
  output logic                 overflow,
  output logic [LOGDEPTH:0]    count,
  output logic                 empty
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam int CW = LOGDEPTH + 1;

  logic [NONCEBITS-1:0] mem_q [DEPTH];

  state_t               state_q, state_d;
  logic [NONCEBITS-1:0] sreg_q, sreg_d;
  logic [1:0]           idx_q, idx_d;
  logic [LOGDEPTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LOGDEPTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 overflow_q, overflow_d;

  logic full;
  logic pop;
  logic push_req;
  logic push_ok;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign pop      = (state_q == IDLE) && !empty && !clear;
  assign push_req = resultValid && success && !clear;
  assign push_ok  = push_req && (!full || pop);

  assign outValid = (state_q == SEND);
  assign outByte  = sreg_q[NONCEBITS-1 -: 8];
  assign overflow = overflow_q;
  assign count    = count_q;

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= nonce;
  end

  // Next-state: FIFO bookkeeping and the serializer FSM.
  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    idx_d      = idx_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clear) begin
      state_d    = IDLE;
      sreg_d     = '0;
      idx_d      = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (push_req && !push_ok) overflow_d = 1'b1;
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push_ok) - CW'(pop);
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            state_d = SEND;
            sreg_d  = mem_q[rd_ptr_q];
            idx_d   = '0;
          end
        end
        SEND: begin
          if (outReady) begin
            sreg_d = {sreg_q[NONCEBITS-9:0], 8'h00};
            idx_d  = idx_q + 1'b1;
            if (idx_q == 2'd3) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      sreg_q     <= '0;
      idx_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      idx_q      <= idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

endmodule
